// File: rtl/md_sequencer_if.sv
// ============================================================================
// Module      : md_sequencer_if
// Description : Command, stall and HI/LO result bundle between the pipeline
//               and the multiply/divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface md_sequencer_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        md_use;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, a, b, flush, md_use,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, md_op, a, b, flush, md_use,
        output busy, stall, done, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/md_sequencer.sv
// ============================================================================
// Module      : md_sequencer
// Description : Multi-cycle mult/div sequencer owning HI/LO, with stall
//               request for HI/LO-dependent instructions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  wire logic      clk,
    input  wire logic      reset,
    md_sequencer_if.slave  md
);

    localparam logic [2:0]       c_OP_MULT  = 3'd1;
    localparam logic [2:0]       c_OP_MULTU = 3'd2;
    localparam logic [2:0]       c_OP_DIV   = 3'd3;
    localparam logic [2:0]       c_OP_DIVU  = 3'd4;
    localparam logic [2:0]       c_OP_MTHI  = 3'd5;
    localparam logic [2:0]       c_OP_MTLO  = 3'd6;
    localparam logic [CNT_W-1:0] c_MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] c_DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic             r_done;
    logic             w_load;
    logic             w_done_nxt;
    logic [31:0]      w_hi_nxt;
    logic [31:0]      w_lo_nxt;

    logic             w_in_mult;
    logic             w_in_div;
    logic             w_busy;

    assign w_in_mult = (md.md_op == c_OP_MULT) || (md.md_op == c_OP_MULTU);
    assign w_in_div  = (md.md_op == c_OP_DIV)  || (md.md_op == c_OP_DIVU);
    assign w_busy    = (r_state == S_RUN);

    // Datapath works on the latched operands; one shared 64-bit multiplier.
    logic        w_op_mult;
    logic        w_sgn_mul;
    logic        w_sgn_div;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_prod;
    logic        w_div_zero;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_op_mult  = (r_op == c_OP_MULT) || (r_op == c_OP_MULTU);
    assign w_sgn_mul  = (r_op == c_OP_MULT);
    assign w_sgn_div  = (r_op == c_OP_DIV);
    assign w_mul_a    = {(w_sgn_mul ? {32{r_a[31]}} : 32'd0), r_a};
    assign w_mul_b    = {(w_sgn_mul ? {32{r_b[31]}} : 32'd0), r_b};
    assign w_prod     = w_mul_a * w_mul_b;

    // Magnitude division avoids the INT_MIN / -1 overflow case entirely.
    assign w_div_zero = (r_b == 32'd0);
    assign w_dvd      = (w_sgn_div && r_a[31]) ? (~r_a + 32'd1) : r_a;
    assign w_dvs      = w_div_zero ? 32'd1 :
                        ((w_sgn_div && r_b[31]) ? (~r_b + 32'd1) : r_b);
    assign w_q_mag    = w_dvd / w_dvs;
    assign w_r_mag    = w_dvd % w_dvs;
    assign w_quo      = (w_sgn_div && (r_a[31] ^ r_b[31])) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem      = (w_sgn_div && r_a[31]) ? (~w_r_mag + 32'd1) : w_r_mag;
    assign w_res_hi   = w_op_mult ? w_prod[63:32] : w_rem;
    assign w_res_lo   = w_op_mult ? w_prod[31:0]  : w_quo;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_done_nxt  = 1'b0;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            S_IDLE: begin
                if (md.start && !md.flush) begin
                    if (w_in_mult || w_in_div) begin
                        w_load      = 1'b1;
                        w_cnt_nxt   = w_in_mult ? c_MULT_CNT : c_DIV_CNT;
                        w_state_nxt = S_RUN;
                    end else if (md.md_op == c_OP_MTHI) begin
                        w_hi_nxt = md.a;
                    end else if (md.md_op == c_OP_MTLO) begin
                        w_lo_nxt = md.a;
                    end
                end
            end
            S_RUN: begin
                if (md.flush) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_CNT_ONE) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                    // A zero divisor still pulses done but leaves HI/LO alone.
                    if (w_op_mult || !w_div_zero) begin
                        w_hi_nxt = w_res_hi;
                        w_lo_nxt = w_res_lo;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= 3'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_done  <= w_done_nxt;
            if (w_load) begin
                r_op <= md.md_op;
                r_a  <= md.a;
                r_b  <= md.b;
            end
        end
    end

    assign md.busy  = w_busy;
    assign md.done  = r_done;
    assign md.hi    = r_hi;
    assign md.lo    = r_lo;
    assign md.stall = md.md_use & (w_busy | (md.start & (w_in_mult | w_in_div)));

endmodule

`default_nettype wire

// File: tb/tb_md_sequencer.sv
// ============================================================================
// Module      : tb_md_sequencer
// Description : Directed self-checking bench for md_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_sequencer;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    md_sequencer_if md_if ();

    md_sequencer #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .md    (md_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        md_if.start = 1'b0;
        md_if.md_op = 3'd0;
        md_if.a     = 32'd0;
        md_if.b     = 32'd0;
        md_if.flush = 1'b0;
    endtask

    // Issue one mult/div with md_use held, then follow it to completion.
    task automatic do_op(input string tag, input logic [2:0] op,
                         input logic [31:0] av, input logic [31:0] bv,
                         input int exp_n, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input bit second);
        int n;
        int dones;
        bit stall_ok;
        md_if.start  = 1'b1;
        md_if.md_op  = op;
        md_if.a      = av;
        md_if.b      = bv;
        md_if.md_use = 1'b1;
        #1;
        check({tag, "_stall_issue"}, md_if.stall, 1);
        tick();
        idle_inputs();
        n = 0;
        dones = 0;
        stall_ok = 1'b1;
        while (md_if.busy && n < 40) begin
            n++;
            if (!md_if.stall) stall_ok = 1'b0;
            if (md_if.done)   dones++;
            if (second && n == 2) begin
                md_if.start = 1'b1;
                md_if.md_op = 3'd1;
                md_if.a     = 32'd5;
                md_if.b     = 32'd5;
            end else begin
                idle_inputs();
            end
            tick();
        end
        idle_inputs();
        check({tag, "_busy_cycles"}, n, exp_n);
        check({tag, "_stall_busy"}, stall_ok, 1);
        check({tag, "_done_early"}, dones, 0);
        check({tag, "_done"}, md_if.done, 1);
        check({tag, "_stall_end"}, md_if.stall, 0);
        check({tag, "_hi"}, md_if.hi, exp_hi);
        check({tag, "_lo"}, md_if.lo, exp_lo);
        tick();
        check({tag, "_done_once"}, md_if.done, 0);
        md_if.md_use = 1'b0;
    endtask

    task automatic move_to(input logic [2:0] op, input logic [31:0] av);
        md_if.start = 1'b1;
        md_if.md_op = op;
        md_if.a     = av;
        tick();
        idle_inputs();
    endtask

    initial begin
        int dones;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        md_if.md_use = 1'b0;
        idle_inputs();
        tick();
        tick();
        check("rst_busy", md_if.busy, 0);
        check("rst_done", md_if.done, 0);
        check("rst_hi", md_if.hi, 0);
        check("rst_lo", md_if.lo, 0);
        check("rst_stall", md_if.stall, 0);
        reset = 1'b1;
        tick();

        do_op("mult",  3'd1, 32'hFFFF_FFFE, 32'd3,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        do_op("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        do_op("div",   3'd3, 32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
        do_op("div_nb",3'd3, 32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        do_op("div_ov",3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000, 1'b0);
        do_op("divu",  3'd4, 32'd100,       32'd7,         10, 32'h0000_0002, 32'h0000_000E, 1'b0);

        move_to(3'd5, 32'h11);
        move_to(3'd6, 32'h22);
        do_op("divu0", 3'd4, 32'd7, 32'd0, 10, 32'h11, 32'h22, 1'b0);

        md_if.start = 1'b1;
        md_if.md_op = 3'd5;
        md_if.a     = 32'h1234;
        md_if.md_use = 1'b1;
        #1;
        check("mthi_stall", md_if.stall, 0);
        tick();
        check("mthi_hi", md_if.hi, 32'h1234);
        check("mthi_lo", md_if.lo, 32'h22);
        check("mthi_busy", md_if.busy, 0);
        md_if.md_op = 3'd6;
        md_if.a     = 32'h5678;
        tick();
        check("mtlo_lo", md_if.lo, 32'h5678);
        check("mtlo_hi", md_if.hi, 32'h1234);
        check("mtlo_busy", md_if.busy, 0);
        check("mtlo_done", md_if.done, 0);
        idle_inputs();
        md_if.md_use = 1'b0;

        md_if.start = 1'b1;
        md_if.md_op = 3'd3;
        #1;
        check("stall_nouse", md_if.stall, 0);
        idle_inputs();

        // Flush at busy cycle 3 of a mult.
        md_if.start = 1'b1;
        md_if.md_op = 3'd1;
        md_if.a     = 32'd3;
        md_if.b     = 32'd4;
        tick();
        idle_inputs();
        tick();
        tick();
        check("flush_busy_pre", md_if.busy, 1);
        md_if.flush = 1'b1;
        tick();
        md_if.flush = 1'b0;
        check("flush_busy", md_if.busy, 0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (md_if.done) dones++;
            tick();
        end
        check("flush_done", dones, 0);
        check("flush_hi", md_if.hi, 32'h1234);
        check("flush_lo", md_if.lo, 32'h5678);

        md_if.flush = 1'b1;
        move_to(3'd5, 32'hDEAD);
        check("flush_idle_mthi", md_if.hi, 32'h1234);
        md_if.flush = 1'b1;
        md_if.b     = 32'd2;
        move_to(3'd1, 32'd3);
        check("flush_idle_mult", md_if.busy, 0);

        move_to(3'd7, 32'hBEEF);
        check("op7_busy", md_if.busy, 0);
        check("op7_hi", md_if.hi, 32'h1234);
        check("op7_lo", md_if.lo, 32'h5678);
        move_to(3'd0, 32'hBEEF);
        check("op0_busy", md_if.busy, 0);
        check("op0_lo", md_if.lo, 32'h5678);

        // Asynchronous reset in the middle of a mult.
        md_if.start = 1'b1;
        md_if.md_op = 3'd1;
        md_if.a     = 32'd9;
        md_if.b     = 32'd9;
        tick();
        idle_inputs();
        tick();
        tick();
        check("rstmid_busy_pre", md_if.busy, 1);
        #2;
        reset = 1'b0;
        #1;
        check("rstmid_busy", md_if.busy, 0);
        check("rstmid_hi", md_if.hi, 0);
        check("rstmid_lo", md_if.lo, 0);
        check("rstmid_done", md_if.done, 0);
        tick();
        reset = 1'b1;
        tick();

        do_op("mult_post", 3'd1, 32'd6, 32'd7, 5, 32'd0, 32'd42, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Sequences the multiply/divide datapath beside the ALU. Accepts a mult/div/mthi/mtlo command from the E stage, latches the operands and counts out a fixed multi-cycle latency. Commits the result to HI/LO and drives the pipeline stall request for HI/LO-dependent instructions.
- The opcode/function decoder supplies md_op and md_use.
- HI/LO are read by mfhi/mflo through the hi/lo outputs.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low; clears all state
- start  input  1  E-stage instruction is a valid MD command this cycle
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- a  input  32  rs operand
- b  input  32  rt operand
- flush  input  1  abort the in-flight operation (exception/flush)
- md_use  input  1  D-stage instruction is mult/div/mthi/mtlo/mfhi/mflo
- busy  output  1  operation in flight
- stall  output  1  combinational stall request to the hazard unit
- done  output  1  one-cycle pulse: result committed this edge
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (reset=0, async): busy=0, done=0, counter=0, hi=0, lo=0, latched op/operands=0. stall follows its equation.
- States:
  - IDLE (counter==0)
  - RUN (counter!=0)
  - busy = RUN.
- IDLE, start=1, md_op in {1..4}:
  - latch a, b, md_op.
  - counter <= MULT_CYCLES (op 1,2) or DIV_CYCLES (op 3,4).
  - Enter RUN at the next edge.
- IDLE, start=1, md_op=5: hi <= a at the next edge. md_op=6: lo <= a. No busy, no done.
- RUN: counter decrements each edge. On the edge where counter goes 1->0:
  - HI/LO are written.
  - done=1 for exactly the following cycle.
  - busy=0 in that same cycle.
- Latency: start sampled at edge t; busy high for cycles t+1 .. t+N; new hi/lo visible from cycle t+N+1.
- Arithmetic, computed from the latched operands:
  - mult: signed 64-bit product. multu: unsigned 64-bit product. {hi,lo} = product.
  - div: signed. lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned. lo = quotient, hi = remainder.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divisor 0 (div or divu): the counter still runs the full DIV_CYCLES; hi/lo are left unchanged; done still pulses.
- start while RUN: ignored; operands and counter are not disturbed. Correct pipelines never issue this because stall holds the D stage.
- flush:
  - Synchronous. In RUN: counter <= 0, no commit, no done; hi/lo keep their old values.
  - flush has priority over start and over a completion on the same edge.
  - In IDLE: suppresses any start/mthi/mtlo on that edge.
- stall = md_use & (busy | (start & md_op in {1..4})). Purely combinational; no dependence on done.
- Reset asserted mid-operation: all state clears immediately; no commit.
- md_op 0 or 7 with start=1: no effect.

Test Plan:
- Reset, then start mult with a=0xFFFFFFFE (-2), b=3 -> busy high exactly 5 cycles; done pulses once; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
- div a=-7 (0xFFFFFFF9), b=2 -> 10 busy cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=0 with prior hi=0x11, lo=0x22 -> hi/lo unchanged; done pulses after 10 cycles.
- md_use=1 held during the start cycle and all busy cycles -> stall=1 through cycle t+N, 0 at t+N+1. A second start issued mid-run is ignored and the result matches the first op.
- mthi a=0x1234 then mtlo a=0x5678 back-to-back in IDLE -> hi=0x1234, lo=0x5678 one edge after each; busy stays 0.
- Start mult, assert flush at busy cycle 3 -> busy drops next cycle, no done, hi/lo unchanged. Repeat with reset pulled low at cycle 3 -> hi=lo=0, busy=0 immediately.
